// File: rtl/vga_pkg.sv
// Shared definitions for the VGA mode-change sequencer: mode encoding,
// pixel divider ratios and the sequencer state encoding.
package vga_pkg;

  localparam logic MODE_640X480 = 1'b0;
  localparam logic MODE_800X600 = 1'b1;

  localparam int DIV_640 = 4;
  localparam int DIV_800 = 2;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    SETTLE  = 2'd1,
    RUN     = 2'd2,
    WAIT_VS = 2'd3
  } state_t;

  // Last divider phase (ratio - 1) for a given mode; P_CLK fires on this phase.
  function automatic logic [1:0] div_last(input logic mode);
    return (mode == MODE_800X600) ? 2'(DIV_800 - 1) : 2'(DIV_640 - 1);
  endfunction

endpackage

// File: rtl/vga_pclk_div.sv
// Pixel-clock strobe generator: a 2-bit phase counter that wraps at the
// ratio selected by the current mode and is held at zero while cleared.
module vga_pclk_div
  import vga_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic mode,
  output logic p_clk
);

  logic [1:0] div_cnt;
  logic [1:0] last;

  assign last = div_last(mode);

  // Phase counter: cleared during HOLD, otherwise counts and wraps on the last phase
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      div_cnt <= '0;
    end else if (div_cnt >= last) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 2'd1;
    end
  end

  // Strobe is suppressed outright while cleared so HOLD never emits a pulse
  assign p_clk = ~clr & (div_cnt == last);

endmodule

// File: rtl/vga_mode_ctrl.sv
// Mode-change sequencer for the VGA sync generator. Mode switches are
// applied inside vertical blank: video is blanked, the sync generator is
// held in reset while the mode changes, and video returns after a number
// of whole frames have gone by.
module vga_mode_ctrl
  import vga_pkg::*;
#(
  parameter logic DEFAULT_MODE  = MODE_640X480,
  parameter int   HOLD_CYCLES   = 4,
  parameter int   SETTLE_FRAMES = 2,
  parameter int   WAIT_TIMEOUT  = 2000000
) (
  input  logic clk,
  input  logic rst,
  input  logic req_valid,
  input  logic req_mode,
  output logic req_ready,
  input  logic vsync,
  output logic mode,
  output logic p_clk,
  output logic sync_rst_n,
  output logic video_en,
  output logic busy
);

  localparam int HOLD_W  = $clog2(HOLD_CYCLES + 1);
  localparam int FRAME_W = $clog2(SETTLE_FRAMES + 1);
  localparam logic [20:0] TIMEOUT_LAST = 21'(WAIT_TIMEOUT - 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(SETTLE_FRAMES - 1);

  state_t state;
  state_t state_next;

  logic               vs_q;
  logic               vs_fall;
  logic               timeout_hit;
  logic               frame_event;
  logic               state_change;
  logic               pend;
  logic [20:0]        wait_cnt;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [FRAME_W-1:0] frame_cnt;

  // A falling VSYNC marks the start of the sync pulse, safely inside vertical blank.
  // A missing VSYNC is covered by the timeout so the sequence can never stall.
  assign vs_fall      = vs_q & ~vsync;
  assign timeout_hit  = (wait_cnt == TIMEOUT_LAST);
  assign frame_event  = vs_fall | timeout_hit;
  assign state_change = (state_next != state);

  // Sequencer state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HOLD;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode
  always_comb begin
    state_next = state;
    case (state)
      HOLD:    if (hold_cnt == HOLD_LAST) state_next = SETTLE;
      SETTLE:  if (frame_event && (frame_cnt == FRAME_LAST)) state_next = RUN;
      RUN:     if (req_valid && (req_mode != mode)) state_next = WAIT_VS;
      WAIT_VS: if (frame_event) state_next = HOLD;
      default: state_next = HOLD;
    endcase
  end

  // Hold, frame and timeout counters; every state starts with all of them at zero
  always_ff @(posedge clk) begin
    if (rst || state_change) begin
      hold_cnt  <= '0;
      frame_cnt <= '0;
      wait_cnt  <= '0;
    end else begin
      if (state == HOLD) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
      if ((state == SETTLE) && frame_event) begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
        wait_cnt  <= '0;
      end else if (((state == SETTLE) || (state == WAIT_VS)) && !timeout_hit) begin
        wait_cnt <= wait_cnt + 21'd1;
      end
    end
  end

  // VSYNC history, pending request and the mode register handed to the sync generator
  always_ff @(posedge clk) begin
    if (rst) begin
      vs_q <= 1'b1;
      pend <= DEFAULT_MODE;
      mode <= DEFAULT_MODE;
    end else begin
      vs_q <= vsync;
      if ((state == RUN) && (state_next == WAIT_VS)) begin
        pend <= req_mode;
      end
      if ((state == WAIT_VS) && (state_next == HOLD)) begin
        mode <= pend;
      end
    end
  end

  assign req_ready  = (state == RUN);
  assign busy       = (state != RUN);
  assign video_en   = (state == RUN) || (state == WAIT_VS);
  assign sync_rst_n = (state != HOLD);

  vga_pclk_div u_pclk_div (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == HOLD),
    .mode  (mode),
    .p_clk (p_clk)
  );

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Self-checking bench for vga_mode_ctrl: a frame-level model of the
// mode-change sequence checked every cycle, plus directed scenarios with
// hand-computed cycle counts.
module tb_vga_mode_ctrl;

  localparam logic DEF_MODE  = 1'b0;
  localparam int   HOLD_N    = 4;
  localparam int   SETTLE_N  = 2;
  localparam int   TIMEOUT_N = 100;
  localparam int   VS_PERIOD = 60;

  logic clk       = 1'b0;
  logic rst       = 1'b1;
  logic req_valid = 1'b0;
  logic req_mode  = 1'b0;
  logic vsync     = 1'b1;
  logic req_ready, mode, p_clk, sync_rst_n, video_en, busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  bit vs_en    = 1'b0;
  int fall_cycles[$];

  vga_mode_ctrl #(
    .DEFAULT_MODE  (DEF_MODE),
    .HOLD_CYCLES   (HOLD_N),
    .SETTLE_FRAMES (SETTLE_N),
    .WAIT_TIMEOUT  (TIMEOUT_N)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_mode   (req_mode),
    .req_ready  (req_ready),
    .vsync      (vsync),
    .mode       (mode),
    .p_clk      (p_clk),
    .sync_rst_n (sync_rst_n),
    .video_en   (video_en),
    .busy       (busy)
  );

  // 100 MHz clock and a cycle counter used to timestamp events
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // VSYNC source: a 4-cycle low pulse every VS_PERIOD cycles while enabled
  initial begin : vs_gen
    int ph;
    ph = 1;
    forever begin
      @(posedge clk);
      #2;
      if (vs_en) begin
        ph = (ph + 1) % VS_PERIOD;
        if (ph == 0) begin
          vsync = 1'b0;
          fall_cycles.push_back(cyc);
        end else if (ph == 4) begin
          vsync = 1'b1;
        end
      end else begin
        vsync = 1'b1;
        ph    = 1;
      end
    end
  end

  // Reference model: tracks which phase of the switch sequence we are in using
  // countdowns, and derives the pixel strobe from cycles elapsed since HOLD
  typedef enum int {M_HOLD, M_SETTLE, M_RUN, M_WAIT} mphase_t;
  mphase_t m_phase   = M_HOLD;
  logic    m_mode    = DEF_MODE;
  logic    m_pend    = DEF_MODE;
  logic    m_vs_prev = 1'b1;
  int      m_hold_left, m_frames_left, m_quiet, m_age;
  bit      m_valid   = 1'b0;

  always @(posedge clk) begin : model
    logic fall;
    fall      = m_vs_prev && !vsync;
    m_vs_prev = vsync;
    if (rst) begin
      m_phase     = M_HOLD;
      m_mode      = DEF_MODE;
      m_hold_left = HOLD_N;
      m_quiet     = 0;
      m_age       = 0;
      m_vs_prev   = 1'b1;
      m_valid     = 1'b1;
    end else begin
      case (m_phase)
        M_HOLD: begin
          m_hold_left--;
          if (m_hold_left == 0) begin
            m_phase       = M_SETTLE;
            m_frames_left = SETTLE_N;
            m_quiet       = 0;
            m_age         = 0;
          end
        end
        M_SETTLE: begin
          m_quiet++;
          m_age++;
          if (fall || m_quiet == TIMEOUT_N) begin
            m_quiet = 0;
            m_frames_left--;
            if (m_frames_left == 0) m_phase = M_RUN;
          end
        end
        M_RUN: begin
          m_age++;
          if (req_valid && req_mode != m_mode) begin
            m_pend  = req_mode;
            m_phase = M_WAIT;
            m_quiet = 0;
          end
        end
        M_WAIT: begin
          m_quiet++;
          m_age++;
          if (fall || m_quiet == TIMEOUT_N) begin
            m_mode      = m_pend;
            m_phase     = M_HOLD;
            m_hold_left = HOLD_N;
          end
        end
        default: m_phase = M_HOLD;
      endcase
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Every-cycle comparison of the DUT against the model, away from the active edge
  always @(negedge clk) begin : compare
    int d;
    if (m_valid) begin
      d = m_mode ? 2 : 4;
      checkOutput("model req_ready", int'(req_ready), int'(m_phase == M_RUN));
      checkOutput("model busy", int'(busy), int'(m_phase != M_RUN));
      checkOutput("model video_en", int'(video_en), int'(m_phase == M_RUN || m_phase == M_WAIT));
      checkOutput("model sync_rst_n", int'(sync_rst_n), int'(m_phase != M_HOLD));
      checkOutput("model mode", int'(mode), int'(m_mode));
      checkOutput("model p_clk", int'(p_clk), int'(m_phase != M_HOLD && (m_age % d) == d - 1));
    end
  end

  task automatic applyStimulus(input logic r, input logic v, input logic m);
    @(negedge clk);
    rst       = r;
    req_valid = v;
    req_mode  = m;
  endtask

  function automatic logic sig(input int which);
    case (which)
      0:       return sync_rst_n;
      1:       return video_en;
      2:       return req_ready;
      3:       return p_clk;
      default: return 1'b0;
    endcase
  endfunction

  task automatic waitFor(input int which, input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (sig(which) != val && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sig(which) != val) checkOutput({name, " wait expired"}, int'(sig(which)), int'(val));
  endtask

  task automatic countWhile(input int which, input logic val, input int budget, output int n);
    n = 0;
    while (sig(which) == val && n < budget) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic firstPulse(output int n);
    n = 1;
    while (!p_clk && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic measurePeriod(output int p);
    int t0;
    waitFor(3, 1'b1, 20, "pclk first");
    t0 = cyc;
    @(negedge clk);
    waitFor(3, 1'b1, 20, "pclk second");
    p = cyc - t0;
  endtask

  function automatic int fallsSince(input int from_cyc);
    int c;
    c = 0;
    foreach (fall_cycles[i]) if (fall_cycles[i] >= from_cyc) c++;
    return c;
  endfunction

  function automatic int lastFall();
    if (fall_cycles.size() == 0) return -100;
    return fall_cycles[fall_cycles.size() - 1];
  endfunction

  initial begin : watchdog
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin : stim
    int n, p, s_cyc, w_cyc;

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset sync_rst_n", int'(sync_rst_n), 0);
    checkOutput("reset video_en", int'(video_en), 0);
    checkOutput("reset req_ready", int'(req_ready), 0);
    checkOutput("reset busy", int'(busy), 1);
    checkOutput("reset p_clk", int'(p_clk), 0);
    checkOutput("reset mode", int'(mode), 0);

    // Startup: HOLD 4 cycles, mode-0 strobe every 4, video after 2 VSYNC falls
    vs_en = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);
    countWhile(0, 1'b0, 50, n);
    checkOutput("startup hold length", n, 4);
    s_cyc = cyc;
    firstPulse(n);
    checkOutput("startup first pclk settle cycle", n, 4);
    measurePeriod(p);
    checkOutput("startup pclk period", p, 4);
    waitFor(1, 1'b1, 400, "startup video");
    checkOutput("startup falls in settle", fallsSince(s_cyc), 2);
    checkOutput("startup video after fall", cyc - lastFall(), 1);
    checkOutput("startup req_ready", int'(req_ready), 1);

    // Switch to mode 1 through VSYNC
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("switch ready drop", int'(req_ready), 0);
    checkOutput("switch video during wait", int'(video_en), 1);
    waitFor(0, 1'b0, 200, "switch hold");
    checkOutput("switch hold after fall", cyc - lastFall(), 1);
    checkOutput("switch mode loaded", int'(mode), 1);
    checkOutput("switch video blanked", int'(video_en), 0);
    countWhile(0, 1'b0, 50, n);
    checkOutput("switch hold length", n, 4);
    s_cyc = cyc;
    firstPulse(n);
    checkOutput("switch first pclk settle cycle", n, 2);
    measurePeriod(p);
    checkOutput("switch pclk period", p, 2);
    waitFor(1, 1'b1, 400, "switch video");
    checkOutput("switch falls in settle", fallsSince(s_cyc), 2);
    checkOutput("switch video after fall", cyc - lastFall(), 1);

    // Request for the mode already running: accepted with no effect
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("same-mode req_ready", int'(req_ready), 1);
    checkOutput("same-mode busy", int'(busy), 0);
    checkOutput("same-mode mode", int'(mode), 1);
    checkOutput("same-mode video", int'(video_en), 1);

    // VSYNC held high: both waits are ended by the timeout
    vs_en = 1'b0;
    repeat (5) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    w_cyc = cyc;
    checkOutput("timeout ready drop", int'(req_ready), 0);
    waitFor(0, 1'b0, 300, "timeout hold");
    checkOutput("timeout wait length", cyc - w_cyc, 100);
    countWhile(0, 1'b0, 50, n);
    checkOutput("timeout hold length", n, 4);
    s_cyc = cyc;
    waitFor(1, 1'b1, 400, "timeout video");
    checkOutput("timeout settle length", cyc - s_cyc, 200);
    checkOutput("timeout mode", int'(mode), 0);

    // Request raised during SETTLE waits for RUN, then starts a new switch
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitFor(0, 1'b0, 300, "settle-req hold");
    waitFor(0, 1'b1, 20, "settle-req settle");
    repeat (10) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("settle-req not ready", int'(req_ready), 0);
    waitFor(2, 1'b1, 400, "settle-req run");
    checkOutput("settle-req run video", int'(video_en), 1);
    checkOutput("settle-req run mode", int'(mode), 1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("settle-req accepted", int'(req_ready), 0);
    checkOutput("settle-req busy", int'(busy), 1);
    waitFor(1, 1'b0, 400, "settle-req blank");
    waitFor(1, 1'b1, 600, "settle-req video");
    checkOutput("settle-req new mode", int'(mode), 0);

    // Reset in the middle of a switch to mode 1 discards it
    applyStimulus(1'b0, 1'b1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    waitFor(0, 1'b0, 300, "midhold hold");
    checkOutput("midhold mode before reset", int'(mode), 1);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("midhold mode after reset", int'(mode), 0);
    checkOutput("midhold busy", int'(busy), 1);
    countWhile(0, 1'b0, 50, n);
    checkOutput("midhold hold length", n, 4);
    s_cyc = cyc;
    waitFor(1, 1'b1, 400, "midhold video");
    checkOutput("midhold settle length", cyc - s_cyc, 200);
    checkOutput("midhold pend lost", int'(mode), 0);
    repeat (20) @(negedge clk);
    checkOutput("midhold stays run", int'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
